riscv_mult_issue: RTL and testbench
===================================

Name: riscv_mult_issue

Overview:
- EX-stage issue/collect wrapper placed directly in front of riscv_mult.
- Accepts one multiply request per handshake from the ID/EX pipe and holds operands, operator and sign controls stable in registers for the whole operation, because the sequential multiplier samples its inputs unregistered.
- Generates the level `enable` required by the multiplier, which derives its start pulse from the rising edge of `enable`.
- Captures the 32-bit result into a writeback register with valid/ready handshake.
- Supports flush of the in-flight operation and a hang watchdog.

Parameters:
- TIMEOUT_CYC, 16, cycles in WAIT/DRAIN without mult_ready_i before err_o sets
- CNT_W, 5, width of the watchdog counter (must hold TIMEOUT_CYC)

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- req_valid_i  in  1  multiply request valid
- req_ready_o  out  1  request accepted this cycle when high with req_valid_i
- operator_i  in  3  MUL_MAC32 or MUL_H (decode_param encoding)
- op_a_i  in  32  operand A
- op_b_i  in  32  operand B
- short_signed_i  in  2  11 = mulh, 01 = mulhsu, 00 = mulhu (ignored for MUL_MAC32)
- rd_addr_i  in  5  destination register
- flush_i  in  1  kill the in-flight operation
- mult_enable_o  out  1  to multiplier enable_i
- mult_operator_o  out  3  held operator
- mult_op_a_o  out  32  held operand A
- mult_op_b_o  out  32  held operand B
- mult_short_signed_o  out  2  held sign controls
- mult_result_i  in  32  multiplier result_o
- mult_ready_i  in  1  multiplier ready_o
- mult_ready_o  out  1  to multiplier ready_i; driven high when the result is being captured
- wb_valid_o  out  1  writeback result valid
- wb_ready_i  in  1  writeback accepts result
- wb_data_o  out  32  result
- wb_rd_addr_o  out  5  destination register
- busy_o  out  1  state != IDLE
- err_o  out  1  sticky watchdog error

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE
  - all held registers 0
  - mult_enable_o = 0, wb_valid_o = 0, err_o = 0, counter = 0
- States: IDLE, LAUNCH, WAIT, DRAIN.
- IDLE:
  - req_ready_o = !flush_i.
  - On req_valid_i && req_ready_o: latch operator, operands, short_signed and rd; go to LAUNCH.
  - mult_enable_o = 0 in IDLE. This guarantees at least one low cycle of enable between operations, which is required for a new start edge.
- LAUNCH:
  - mult_enable_o = 1. The multiplier start pulse occurs in this cycle.
  - mult_ready_i is ignored in this cycle.
  - Go to WAIT, or to DRAIN if flush_i.
- WAIT:
  - mult_enable_o = 1.
  - When mult_ready_i && (!wb_valid_o || wb_ready_i): capture mult_result_i and rd into the wb register, set wb_valid_o next cycle, pulse mult_ready_o, go to IDLE.
  - If the result is ready but the wb register is occupied and not draining, stay in WAIT. The multiplier holds complete and its result while enable stays high and the inputs are held.
  - flush_i (absent a same-cycle capture) -> DRAIN.
  - A capture and flush_i in the same cycle: the capture wins and the flush is a no-op, since the operation is complete.
- DRAIN:
  - mult_enable_o = 0; operands stay held.
  - On mult_ready_i: discard the result, go to IDLE. wb_valid_o is not set.
- Writeback register:
  - wb_valid_o clears on wb_ready_i unless it is reloaded the same cycle.
  - flush_i does not clear an already-captured wb result.
- Latency: with the multiplier at num_cyc=3, request accept at cycle T, start at T+1, wb_valid_o at T+5. The bench checks against the multiplier's actual ready, not a constant.
- Throughput: one operation per 5 cycles at best; the IDLE gap is mandatory.
- Watchdog:
  - Counter clears on entering LAUNCH and increments in WAIT/DRAIN while mult_ready_i is low.
  - When it reaches TIMEOUT_CYC, err_o sets and stays set until reset.
  - State is not changed by the watchdog.
- Held outputs (mult_operator_o, mult_op_a_o, mult_op_b_o, mult_short_signed_o) change only on request accept in IDLE. They must be stable from LAUNCH through the ready cycle, including DRAIN.
- Reset mid-operation returns everything to IDLE immediately. The multiplier shares rst_n.

Decomposition:
- Package riscv_mult_issue_pkg holds:
  - the state enum
  - MUL_MAC32/MUL_H re-exported from decode_param
  - short_signed encodings MULH=2'b11, MULHSU=2'b01, MULHU=2'b00
- No sub-module. The watchdog is an inline counter.
- The bench instantiates riscv_mult_issue with riscv_mult as the real load.

Test Plan:
- MUL_MAC32, a=7, b=0xFFFFFFFD -> single wb_valid_o, wb_data_o=0xFFFFFFEB; rd echoed; enable high exactly LAUNCH..capture.
- MUL_H ss=00, a=b=0xFFFFFFFF -> 0xFFFFFFFE. ss=11, same operands -> 0x00000000. ss=01, a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
- Back-to-back requests with req_valid_i held and wb_ready_i=1 -> mult_enable_o low for at least 1 cycle between ops; two correct results in order.
- wb_ready_i=0 for 10 cycles with a second op completing -> FSM stays in WAIT, first result unchanged; second captured the cycle wb_ready_i rises.
- flush_i in the cycle after LAUNCH -> DRAIN, enable low, operands held, no wb_valid_o; next request accepted after mult_ready_i and produces a correct result.
- mult_ready_i forced low (stub) -> err_o rises exactly TIMEOUT_CYC=16 cycles after LAUNCH and stays high; async rst_n mid-WAIT -> all outputs at reset values within the same cycle.

Source files
------------

// File: rtl/riscv_mult_issue_pkg.sv
// riscv_mult_issue_pkg: shared types and encodings for the multiplier issue wrapper.
package riscv_mult_issue_pkg;
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DRAIN} state_t;
    localparam logic [2:0] MUL_MAC32 = 3'b000;
    localparam logic [2:0] MUL_H     = 3'b110;
    localparam logic [1:0] MULH   = 2'b11;
    localparam logic [1:0] MULHSU = 2'b01;
    localparam logic [1:0] MULHU  = 2'b00;
endpackage

// File: rtl/riscv_mult_issue.sv
// riscv_mult_issue: holds a multiply request stable for riscv_mult, drives its enable level
// and collects the result into a writeback register, with flush and a hang watchdog.
module riscv_mult_issue
    import riscv_mult_issue_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [2:0]  operator_i,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    input  logic [1:0]  short_signed_i,
    input  logic [4:0]  rd_addr_i,
    input  logic        flush_i,
    output logic        mult_enable_o,
    output logic [2:0]  mult_operator_o,
    output logic [31:0] mult_op_a_o,
    output logic [31:0] mult_op_b_o,
    output logic [1:0]  mult_short_signed_o,
    input  logic [31:0] mult_result_i,
    input  logic        mult_ready_i,
    output logic        mult_ready_o,
    output logic        wb_valid_o,
    input  logic        wb_ready_i,
    output logic [31:0] wb_data_o,
    output logic [4:0]  wb_rd_addr_o,
    output logic        busy_o,
    output logic        err_o
);
    state_t           state;
    logic [4:0]       rd_q;
    logic [CNT_W-1:0] wd_cnt;
    logic             capture;

    // capture beats a same-cycle flush: the operation is already complete
    assign capture      = (state == WAIT) && mult_ready_i && (!wb_valid_o || wb_ready_i);
    assign req_ready_o  = (state == IDLE) && !flush_i;
    assign mult_ready_o = capture;
    assign busy_o       = state != IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= IDLE;
            mult_enable_o       <= 1'b0;
            mult_operator_o     <= '0;
            mult_op_a_o         <= '0;
            mult_op_b_o         <= '0;
            mult_short_signed_o <= '0;
            rd_q                <= '0;
            wb_valid_o          <= 1'b0;
            wb_data_o           <= '0;
            wb_rd_addr_o        <= '0;
            wd_cnt              <= '0;
            err_o               <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid_i && !flush_i) begin
                    mult_operator_o     <= operator_i;
                    mult_op_a_o         <= op_a_i;
                    mult_op_b_o         <= op_b_i;
                    mult_short_signed_o <= short_signed_i;
                    rd_q                <= rd_addr_i;
                    mult_enable_o       <= 1'b1;
                    wd_cnt              <= '0;
                    state               <= LAUNCH;
                end
                LAUNCH: begin
                    mult_enable_o <= !flush_i;
                    state         <= flush_i ? DRAIN : WAIT;
                end
                WAIT: if (capture) begin
                    mult_enable_o <= 1'b0;
                    state         <= IDLE;
                end else if (flush_i) begin
                    mult_enable_o <= 1'b0;
                    state         <= DRAIN;
                end
                DRAIN: if (mult_ready_i) state <= IDLE;
                default: state <= IDLE;
            endcase
            if (capture) begin
                wb_valid_o   <= 1'b1;
                wb_data_o    <= mult_result_i;
                wb_rd_addr_o <= rd_q;
            end else if (wb_ready_i) begin
                wb_valid_o <= 1'b0;
            end
            // saturating watchdog; err latches on the edge the count reaches TIMEOUT_CYC
            if ((state == WAIT || state == DRAIN) && !mult_ready_i) begin
                if (wd_cnt != '1) wd_cnt <= wd_cnt + 1'b1;
                if (wd_cnt == CNT_W'(TIMEOUT_CYC - 1)) err_o <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_riscv_mult_issue.sv
// tb_riscv_mult_issue: directed checks of the issue wrapper against a behavioural
// sequential multiplier (3 cycles, start on enable rise, result held while enabled).
module tb_riscv_mult_issue;
    import riscv_mult_issue_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [2:0]  operator_i = '0;
    logic [31:0] op_a_i = '0;
    logic [31:0] op_b_i = '0;
    logic [1:0]  short_signed_i = '0;
    logic [4:0]  rd_addr_i = '0;
    logic        flush_i = 1'b0;
    logic        mult_enable_o;
    logic [2:0]  mult_operator_o;
    logic [31:0] mult_op_a_o;
    logic [31:0] mult_op_b_o;
    logic [1:0]  mult_short_signed_o;
    logic [31:0] mult_result_i;
    logic        mult_ready_i;
    logic        mult_ready_o;
    logic        wb_valid_o;
    logic        wb_ready_i = 1'b1;
    logic [31:0] wb_data_o;
    logic [4:0]  wb_rd_addr_o;
    logic        busy_o;
    logic        err_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    riscv_mult_issue #(.TIMEOUT_CYC(16), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .operator_i(operator_i), .op_a_i(op_a_i), .op_b_i(op_b_i),
        .short_signed_i(short_signed_i), .rd_addr_i(rd_addr_i), .flush_i(flush_i),
        .mult_enable_o(mult_enable_o), .mult_operator_o(mult_operator_o),
        .mult_op_a_o(mult_op_a_o), .mult_op_b_o(mult_op_b_o),
        .mult_short_signed_o(mult_short_signed_o), .mult_result_i(mult_result_i),
        .mult_ready_i(mult_ready_i), .mult_ready_o(mult_ready_o),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_data_o(wb_data_o),
        .wb_rd_addr_o(wb_rd_addr_o), .busy_o(busy_o), .err_o(err_o)
    );

    // multiplier load: short_signed bit0 signs operand A, bit1 signs operand B
    logic [1:0]         m_cnt;
    logic               en_q;
    logic               stall = 1'b0;
    logic signed [32:0] m_a, m_b;
    logic signed [65:0] m_p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt <= '0;
            en_q  <= 1'b0;
        end else begin
            en_q <= mult_enable_o;
            if (mult_enable_o && !en_q) m_cnt <= 2'd1;
            else if (m_cnt == 2'd1 || m_cnt == 2'd2) m_cnt <= m_cnt + 2'd1;
            else if (m_cnt == 2'd3 && (!mult_enable_o || mult_ready_o)) m_cnt <= '0;
        end
    end

    assign mult_ready_i = (m_cnt == 2'd3) && !stall;

    always_comb begin
        m_a = {mult_short_signed_o[0] & mult_op_a_o[31], mult_op_a_o};
        m_b = {mult_short_signed_o[1] & mult_op_b_o[31], mult_op_b_o};
        m_p = 66'(m_a) * 66'(m_b);
        mult_result_i = (mult_operator_o == MUL_H) ? m_p[63:32] : m_p[31:0];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // presents a request and returns at the negedge of the LAUNCH cycle
    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] ss, input logic [4:0] rd);
        int k = 0;
        req_valid_i = 1'b1; operator_i = op; op_a_i = a; op_b_i = b;
        short_signed_i = ss; rd_addr_i = rd;
        while (!req_ready_o && k < 20) begin @(negedge clk); k++; end
        check("accept", 32'(req_ready_o), 32'd1);
        @(negedge clk);
        req_valid_i = 1'b0;
    endtask

    task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [1:0] ss, input logic [4:0] rd,
                         input logic [31:0] exp);
        int n_en = 0;
        int k = 0;
        send(op, a, b, ss, rd);
        while (!wb_valid_o && k < 20) begin
            if (mult_enable_o) n_en++;
            @(negedge clk);
            k++;
        end
        check({tag, "_valid"}, 32'(wb_valid_o), 32'd1);
        check({tag, "_data"}, wb_data_o, exp);
        check({tag, "_rd"}, 32'(wb_rd_addr_o), 32'(rd));
        check({tag, "_en_cycles"}, 32'(n_en), 32'd4);
        @(negedge clk);
        check({tag, "_single"}, 32'(wb_valid_o), 32'd0);
    endtask

    int          acc, upd, rises, nres, nwb, k;
    logic        pe, early;
    logic [31:0] res [2];
    logic [4:0]  rds [2];

    initial begin
        #12;
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_en", 32'(mult_enable_o), 32'd0);
        check("rst_wb_valid", 32'(wb_valid_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_op_a", mult_op_a_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_op("mac32", MUL_MAC32, 32'd7, 32'hFFFF_FFFD, MULHU, 5'd10, 32'hFFFF_FFEB);
        do_op("mulhu", MUL_H, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MULHU, 5'd11, 32'hFFFF_FFFE);
        do_op("mulh", MUL_H, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MULH, 5'd12, 32'h0000_0000);

        // back-to-back with req_valid held
        acc = 0; upd = 0; rises = 0; nres = 0; pe = 1'b0;
        req_valid_i = 1'b1; operator_i = MUL_MAC32; op_a_i = 32'd5; op_b_i = 32'd6;
        short_signed_i = MULHU; rd_addr_i = 5'd1;
        for (int i = 0; i < 20; i++) begin
            if (upd != 0) begin
                if (acc == 1) begin
                    operator_i = MUL_H; op_a_i = 32'h8000_0000; op_b_i = 32'h8000_0000;
                    short_signed_i = MULH; rd_addr_i = 5'd2;
                end else req_valid_i = 1'b0;
                upd = 0;
            end
            if (mult_enable_o && !pe) rises++;
            pe = mult_enable_o;
            if (wb_valid_o && nres < 2) begin
                res[nres] = wb_data_o; rds[nres] = wb_rd_addr_o; nres++;
            end
            if (req_valid_i && req_ready_o) begin acc++; upd = 1; end
            @(negedge clk);
        end
        req_valid_i = 1'b0;
        check("b2b_count", 32'(nres), 32'd2);
        check("b2b_rises", 32'(rises), 32'd2);
        check("b2b_res0", res[0], 32'h0000_001E);
        check("b2b_rd0", 32'(rds[0]), 32'd1);
        check("b2b_res1", res[1], 32'h4000_0000);
        check("b2b_rd1", 32'(rds[1]), 32'd2);

        // writeback backpressure
        wb_ready_i = 1'b0;
        send(MUL_MAC32, 32'd3, 32'd4, MULHU, 5'd3);
        k = 0;
        while (!wb_valid_o && k < 20) begin @(negedge clk); k++; end
        check("bp_first", wb_data_o, 32'd12);
        send(MUL_MAC32, 32'd100, 32'd200, MULHU, 5'd4);
        repeat (10) @(negedge clk);
        check("bp_busy", 32'(busy_o), 32'd1);
        check("bp_en", 32'(mult_enable_o), 32'd1);
        check("bp_hold_data", wb_data_o, 32'd12);
        check("bp_hold_rd", 32'(wb_rd_addr_o), 32'd3);
        check("bp_hold_valid", 32'(wb_valid_o), 32'd1);
        wb_ready_i = 1'b1;
        @(negedge clk);
        check("bp_second", wb_data_o, 32'h0000_4E20);
        check("bp_second_valid", 32'(wb_valid_o), 32'd1);
        check("bp_second_rd", 32'(wb_rd_addr_o), 32'd4);
        check("bp_idle", 32'(busy_o), 32'd0);
        @(negedge clk);
        check("bp_drop", 32'(wb_valid_o), 32'd0);

        // flush in IDLE blocks accept; flush in the first WAIT cycle drains
        flush_i = 1'b1;
        #1 check("flush_no_ready", 32'(req_ready_o), 32'd0);
        @(negedge clk);
        flush_i = 1'b0;
        send(MUL_MAC32, 32'd9, 32'd9, MULHU, 5'd5);
        @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        check("flush_en", 32'(mult_enable_o), 32'd0);
        check("flush_busy", 32'(busy_o), 32'd1);
        check("flush_op_a", mult_op_a_o, 32'd9);
        check("flush_op_b", mult_op_b_o, 32'd9);
        nwb = 0; k = 0;
        while (busy_o && k < 20) begin
            if (wb_valid_o) nwb++;
            @(negedge clk);
            k++;
        end
        check("flush_idle", 32'(busy_o), 32'd0);
        repeat (2) begin
            if (wb_valid_o) nwb++;
            @(negedge clk);
        end
        check("flush_no_wb", 32'(nwb), 32'd0);
        do_op("mulhsu", MUL_H, 32'hFFFF_FFFF, 32'd2, MULHSU, 5'd7, 32'hFFFF_FFFF);

        // watchdog with the multiplier never completing
        stall = 1'b1;
        send(MUL_MAC32, 32'd1, 32'd1, MULHU, 5'd6);
        early = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (err_o) early = 1'b1;
        end
        check("wd_early", 32'(early), 32'd0);
        @(negedge clk);
        check("wd_err", 32'(err_o), 32'd1);
        check("wd_state", 32'(busy_o), 32'd1);
        repeat (5) @(negedge clk);
        check("wd_sticky", 32'(err_o), 32'd1);

        // asynchronous reset mid-WAIT
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy_o), 32'd0);
        check("arst_en", 32'(mult_enable_o), 32'd0);
        check("arst_err", 32'(err_o), 32'd0);
        check("arst_op_a", mult_op_a_o, 32'd0);
        check("arst_wb_data", wb_data_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stall = 1'b0;
        @(negedge clk);
        do_op("post_rst", MUL_MAC32, 32'h1234_5678, 32'h10, MULHU, 5'd31, 32'h2345_6780);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
